hashtable_lane_arb: RTL and testbench

HASHTABLE_LANE_ARB -- requirements
Module: hashtable_lane_arb

---
 rtl/hashtable_lane_arb.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_hashtable_lane_arb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hashtable_lane_arb.sv
// hashtable_lane_arb
//   Round-robin arbiter that feeds up to NREQ requesters into the two lanes
//   of a fixed-latency hashtable. It makes at most two grants per cycle. Each
//   lane carries a {issued, requester id} tag through a shift register that
//   is as deep as the hashtable latency. That tag routes each lane result
//   back to the requester that issued it.
//
//   state_dbg encoding: 0 = IDLE, 1 = RUN, 2 = DRAIN.
//
//   Optional build: define HT_LANE_ARB_STATS_EN to add the saturating 32-bit
//   stat_lookups / stat_hits counters and their ports.
module hashtable_lane_arb #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 16,
    parameter int HT_LAT = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [64*NREQ-1:0]     req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [63:0]            ht_din0,
    output logic                   ht_din0_valid,
    output logic [63:0]            ht_din1,
    output logic                   ht_din1_valid,
    input  logic [DWIDTH-1:0]      ht_dout0,
    input  logic                   ht_dout0_valid,
    input  logic [DWIDTH-1:0]      ht_dout1,
    input  logic                   ht_dout1_valid,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [NREQ-1:0]        rsp_hit,
    output logic [DWIDTH*NREQ-1:0] rsp_addr,
    output logic                   idle,
    output logic [1:0]             state_dbg
`ifdef HT_LANE_ARB_STATS_EN
    ,
    output logic [31:0]            stat_lookups,
    output logic [31:0]            stat_hits
`endif
);

    // Handshake: requester i hands over req_data[i] in any cycle where
    // req_valid[i] && req_ready[i] at the rising edge. req_ready is only ever
    // raised for a requester that is already valid, so a raised ready always
    // means the request was taken. Responses (rsp_valid) cannot be stalled.

    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW_MIN = $clog2(2 * HT_LAT + 3);
    localparam int CW     = (CW_MIN > 4) ? CW_MIN : 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [IDW-1:0] rr;
    logic [CW-1:0]  inflight;

    // Grant selection results
    logic           g0_found;
    logic           g1_found;
    logic [IDW-1:0] g0_idx;
    logic [IDW-1:0] g1_idx;
    logic [IDW:0]   scan_sum;
    logic [IDW-1:0] scan_idx;
    logic [1:0]     n_grant;

    // Requester id travelling alongside each lane register
    logic [IDW-1:0] lane0_id;
    logic [IDW-1:0] lane1_id;

    // Tag pipelines, one per lane; stage HT_LAT-1 lines up with ht_dout*
    logic [HT_LAT-1:0] t0_v;
    logic [HT_LAT-1:0] t1_v;
    logic [IDW-1:0]    t0_id [HT_LAT];
    logic [IDW-1:0]    t1_id [HT_LAT];

    logic           exit0;
    logic           exit1;
    logic [IDW-1:0] exit0_id;
    logic [IDW-1:0] exit1_id;
    logic [1:0]     n_retire;

    // Next round-robin pointer after granting index v
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        if (v == IDW'(NREQ - 1)) begin
            return '0;
        end
        return v + IDW'(1);
    endfunction

    // Scan requesters starting at rr (wrapping); take the first two valid ones
    always_comb begin
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        scan_sum = '0;
        scan_idx = '0;
        if (state == ST_RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_sum = {1'b0, rr} + (IDW + 1)'(k);
                if (scan_sum >= (IDW + 1)'(NREQ)) begin
                    scan_sum = scan_sum - (IDW + 1)'(NREQ);
                end
                scan_idx = scan_sum[IDW-1:0];
                if (req_valid[scan_idx]) begin
                    if (!g0_found) begin
                        g0_found = 1'b1;
                        g0_idx   = scan_idx;
                    end else if (!g1_found) begin
                        g1_found = 1'b1;
                        g1_idx   = scan_idx;
                    end
                end
            end
        end
    end

    // Ready follows the grant decision directly
    always_comb begin
        req_ready = '0;
        if (g0_found) begin
            req_ready[g0_idx] = 1'b1;
        end
        if (g1_found) begin
            req_ready[g1_idx] = 1'b1;
        end
    end

    assign n_grant = {1'b0, g0_found} + {1'b0, g1_found};

    // Tag exit points and retirement count
    assign exit0    = t0_v[HT_LAT-1];
    assign exit1    = t1_v[HT_LAT-1];
    assign exit0_id = t0_id[HT_LAT-1];
    assign exit1_id = t1_id[HT_LAT-1];
    assign n_retire = {1'b0, exit0} + {1'b0, exit1};

    // Mode FSM: grants only in RUN; DRAIN waits for outstanding lookups
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (inflight == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            rr    <= '0;
        end else begin
            state <= state_nxt;
            if (g1_found) begin
                rr <= wrap_inc(g1_idx);
            end else if (g0_found) begin
                rr <= wrap_inc(g0_idx);
            end
        end
    end

    assign idle      = (state == ST_IDLE);
    assign state_dbg = state;

    // Lane input registers: first grant on lane 0, second on lane 1
    always_ff @(posedge clk) begin
        if (rst) begin
            ht_din0       <= '0;
            ht_din0_valid <= 1'b0;
            ht_din1       <= '0;
            ht_din1_valid <= 1'b0;
            lane0_id      <= '0;
            lane1_id      <= '0;
        end else begin
            ht_din0_valid <= g0_found;
            ht_din1_valid <= g1_found;
            ht_din0       <= g0_found ? req_data[{g0_idx, 6'b0} +: 64] : 64'd0;
            ht_din1       <= g1_found ? req_data[{g1_idx, 6'b0} +: 64] : 64'd0;
            lane0_id      <= g0_idx;
            lane1_id      <= g1_idx;
        end
    end

    // Tag shift registers follow the lane registers into the hashtable
    always_ff @(posedge clk) begin
        if (rst) begin
            t0_v <= '0;
            t1_v <= '0;
            for (int s = 0; s < HT_LAT; s++) begin
                t0_id[s] <= '0;
                t1_id[s] <= '0;
            end
        end else begin
            t0_v[0]  <= ht_din0_valid;
            t1_v[0]  <= ht_din1_valid;
            t0_id[0] <= lane0_id;
            t1_id[0] <= lane1_id;
            for (int s = 1; s < HT_LAT; s++) begin
                t0_v[s]  <= t0_v[s-1];
                t1_v[s]  <= t1_v[s-1];
                t0_id[s] <= t0_id[s-1];
                t1_id[s] <= t1_id[s-1];
            end
        end
    end

    // Route lane results to their requester; a result with no issued tag is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_hit   <= '0;
            rsp_addr  <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_hit   <= '0;
            rsp_addr  <= '0;
            if (exit0) begin
                rsp_valid[exit0_id] <= 1'b1;
                rsp_hit[exit0_id]   <= ht_dout0_valid;
                if (ht_dout0_valid) begin
                    rsp_addr[DWIDTH*exit0_id +: DWIDTH] <= ht_dout0;
                end
            end
            if (exit1) begin
                rsp_valid[exit1_id] <= 1'b1;
                rsp_hit[exit1_id]   <= ht_dout1_valid;
                if (ht_dout1_valid) begin
                    rsp_addr[DWIDTH*exit1_id +: DWIDTH] <= ht_dout1;
                end
            end
        end
    end

    // Outstanding lookups: grants in, tag exits out, netted in one update
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + CW'(n_grant) - CW'(n_retire);
        end
    end

`ifdef HT_LANE_ARB_STATS_EN
    logic [1:0] n_hit;

    assign n_hit = {1'b0, exit0 & ht_dout0_valid} + {1'b0, exit1 & ht_dout1_valid};

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Saturating lookup / hit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
        end else begin
            stat_lookups <= sat_add(stat_lookups, n_grant);
            stat_hits    <= sat_add(stat_hits, n_hit);
        end
    end
`endif

endmodule

// File: tb/tb_hashtable_lane_arb.sv
// Bench for hashtable_lane_arb: directed phases driven from one initial block.
// A reference arbiter plus an expected-response queue checks every cycle, and
// a behavioural fixed-latency hashtable answers the lane requests.
module tb_hashtable_lane_arb;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 16;
  localparam int HT_LAT = 6;
  localparam int EW     = 32 + 8 + 1 + DWIDTH;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_RUN   = 2'd1;
  localparam logic [1:0] M_DRAIN = 2'd2;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic [NREQ-1:0]        req_valid;
  logic [64*NREQ-1:0]     req_data;
  logic [NREQ-1:0]        req_ready;
  logic [63:0]            ht_din0, ht_din1;
  logic                   ht_din0_valid, ht_din1_valid;
  logic [DWIDTH-1:0]      ht_dout0 = '0, ht_dout1 = '0;
  logic                   ht_dout0_valid = 1'b0, ht_dout1_valid = 1'b0;
  logic [NREQ-1:0]        rsp_valid, rsp_hit;
  logic [DWIDTH*NREQ-1:0] rsp_addr;
  logic                   idle;
  logic [1:0]             state_dbg;
`ifdef HT_LANE_ARB_STATS_EN
  logic [31:0]            stat_lookups, stat_hits;
`endif

  always #5 clk = ~clk;

  hashtable_lane_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH), .HT_LAT(HT_LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ht_din0(ht_din0), .ht_din0_valid(ht_din0_valid),
    .ht_din1(ht_din1), .ht_din1_valid(ht_din1_valid),
    .ht_dout0(ht_dout0), .ht_dout0_valid(ht_dout0_valid),
    .ht_dout1(ht_dout1), .ht_dout1_valid(ht_dout1_valid),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
    .idle(idle), .state_dbg(state_dbg)
`ifdef HT_LANE_ARB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits)
`endif
  );

  // ---------------- hashtable model ----------------
  // A lookup hits when key bit 32 is set. The result bits are the low DWIDTH
  // key bits and are driven even on a miss.
  logic [63:0] hp0 [HT_LAT+1] = '{default: '0};
  logic [63:0] hp1 [HT_LAT+1] = '{default: '0};
  logic        hv0 [HT_LAT+1] = '{default: 1'b0};
  logic        hv1 [HT_LAT+1] = '{default: 1'b0};

  always @(negedge clk) begin
    for (int k = HT_LAT; k > 0; k--) begin
      hp0[k] = hp0[k-1]; hv0[k] = hv0[k-1];
      hp1[k] = hp1[k-1]; hv1[k] = hv1[k-1];
    end
    hp0[0] = ht_din0; hv0[0] = ht_din0_valid;
    hp1[0] = ht_din1; hv1[0] = ht_din1_valid;
    ht_dout0_valid = hv0[HT_LAT] && hp0[HT_LAT][32];
    ht_dout1_valid = hv1[HT_LAT] && hp1[HT_LAT][32];
    ht_dout0 = hv0[HT_LAT] ? hp0[HT_LAT][DWIDTH-1:0] : '0;
    ht_dout1 = hv1[HT_LAT] ? hp1[HT_LAT][DWIDTH-1:0] : '0;
  end

  // ---------------- scoreboard and reference state ----------------
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cycle  = 0;
  logic [1:0]    m_state = M_IDLE;
  int            m_rr = 0;
  logic          m_l0v = 1'b0, m_l1v = 1'b0;
  logic [63:0]   m_l0d = '0, m_l1d = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [63:0] d);
    req_data[64*i +: 64] = d;
  endtask

  // One clock cycle: check at negedge, advance reference at posedge, return at posedge+1
  task automatic tick();
    logic [NREQ-1:0]        e_v, e_h, e_r;
    logic [DWIDTH*NREQ-1:0] e_a;
    logic [EW-1:0]          ent;
    logic [63:0]            d;
    logic [DWIDTH-1:0]      a;
    int                     id, n;
    int                     pick [2];
    logic                   n0v, n1v;
    logic [63:0]            n0d, n1d;
    @(negedge clk);
    e_v = '0; e_h = '0; e_a = '0;
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      ent = exp_q[j];
      if (ent[EW-1 -: 32] == 32'(cycle)) begin
        id = int'(ent[DWIDTH+8 -: 8]);
        e_v[id] = 1'b1;
        e_h[id] = ent[DWIDTH];
        e_a[id*DWIDTH +: DWIDTH] = ent[DWIDTH-1:0];
        exp_q.delete(j);
      end
    end
    chk("rsp_valid", rsp_valid, e_v);
    chk("rsp_hit", rsp_hit, e_h);
    chk("rsp_addr", rsp_addr, e_a);
    chk("lane0_valid", ht_din0_valid, m_l0v);
    chk("lane0_din", ht_din0, m_l0d);
    chk("lane1_valid", ht_din1_valid, m_l1v);
    chk("lane1_din", ht_din1, m_l1d);
    chk("idle", idle, m_state == M_IDLE);
    chk("state", state_dbg, m_state);
    e_r = '0; n = 0; pick[0] = 0; pick[1] = 0;
    if (m_state == M_RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_rr + k) % NREQ;
        if (req_valid[i] && n < 2) begin
          e_r[i] = 1'b1;
          pick[n] = i;
          n++;
        end
      end
    end
    chk("req_ready", req_ready, e_r);
    n0v = 1'b0; n1v = 1'b0; n0d = '0; n1d = '0;
    for (int g = 0; g < n; g++) begin
      d = req_data[64*pick[g] +: 64];
      a = d[32] ? d[DWIDTH-1:0] : {DWIDTH{1'b0}};
      exp_q.push_back({32'(cycle + HT_LAT + 2), 8'(pick[g]), d[32], a});
      if (g == 0) begin n0v = 1'b1; n0d = d; end
      else begin n1v = 1'b1; n1d = d; end
    end
    @(posedge clk);
    if (rst) begin
      m_state = M_IDLE; m_rr = 0;
      m_l0v = 1'b0; m_l1v = 1'b0; m_l0d = '0; m_l1d = '0;
      exp_q.delete();
    end else begin
      m_l0v = n0v; m_l0d = n0d; m_l1v = n1v; m_l1d = n1d;
      if (n > 0) m_rr = (pick[n-1] + 1) % NREQ;
      case (m_state)
        M_IDLE:  if (en) m_state = M_RUN;
        M_RUN:   if (!en) m_state = M_DRAIN;
        default: begin
          if (en) m_state = M_RUN;
          else if (exp_q.size() == 0) m_state = M_IDLE;
        end
      endcase
    end
    cycle++;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int lat, last_rsp, idle_at, stray;
    logic found;
    rst = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle", idle, 1'b1);
    chk("rst_state", state_dbg, M_IDLE);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_addr", rsp_addr, '0);
    chk("rst_lane0", {ht_din0_valid, ht_din0}, '0);
    chk("rst_lane1", {ht_din1_valid, ht_din1}, '0);
    tick();
    rst = 1'b0;

    // single requester 2: lane 0 only, response HT_LAT+1 after issue
    en = 1'b1;
    tick();
    set_req(2, 64'h1122334455667788);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("a_lane0_din", ht_din0, 64'h1122334455667788);
    chk("a_lane0_valid", ht_din0_valid, 1'b1);
    chk("a_lane1_idle", {ht_din1_valid, ht_din1}, '0);
    lat = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      lat++;
      if (rsp_valid[2]) found = 1'b1;
    end
    chk("a_latency", lat, HT_LAT + 1);

    // all four requesters from rr=0: pairs {0,1},{2,3},...
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, {$urandom, $urandom});
      #1;
      chk("b_pair", req_ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      tick();
    end
    req_valid = '0;
    repeat (10) tick();

    // requester 3 hits on lane 1 with 0x1A2B, requester 2 misses on lane 0
    set_req(2, 64'h0000_0000_0000_5555);
    set_req(3, 64'h0000_0001_0000_1A2B);
    req_valid = 4'b1100;
    tick();
    req_valid = '0;
    chk("c_lane1_din", ht_din1, 64'h0000_0001_0000_1A2B);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (rsp_valid[3]) found = 1'b1;
    end
    chk("c_found", found, 1'b1);
    chk("c_hit3", rsp_hit[3], 1'b1);
    chk("c_addr3", rsp_addr[3*DWIDTH +: DWIDTH], 16'h1A2B);
    chk("c_valid2", rsp_valid[2], 1'b1);
    chk("c_hit2", rsp_hit[2], 1'b0);
    chk("c_addr2", rsp_addr[2*DWIDTH +: DWIDTH], 16'h0000);

    // drop en with five lookups in flight
    req_valid = 4'b1111;
    repeat (2) tick();
    req_valid = 4'b0001; en = 1'b0;
    tick();
    req_valid = 4'b1111;
    last_rsp = -1; idle_at = -1;
    for (int k = 0; k < 30 && idle_at < 0; k++) begin
      #1;
      chk("d_ready_low", req_ready, '0);
      tick();
      if (rsp_valid != '0) last_rsp = k;
      if (idle) idle_at = k;
    end
    chk("d_idle_after_last_rsp", idle_at - last_rsp, 1);
    req_valid = '0;

    // reset two cycles after issue: lookup discarded, rr back to 0
    en = 1'b1;
    tick();
    set_req(1, 64'h0000_0001_0000_BEEF);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0; en = 1'b0;
    chk("e_idle", idle, 1'b1);
    chk("e_state", state_dbg, M_IDLE);
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rsp_valid[1]) stray++;
    end
    chk("e_no_rsp", stray, 0);
    en = 1'b1;
    tick();
    req_valid = 4'b1111;
    #1;
    chk("e_rr_zero", req_ready, 4'b0011);
    tick();
    req_valid = '0;

    // random traffic with occasional en drops
    for (int k = 0; k < 60; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) set_req(i, {$urandom, $urandom});
      en = ($urandom_range(0, 9) != 0);
      tick();
    end
    en = 1'b0; req_valid = '0;
    repeat (20) tick();
    chk("f_drained", exp_q.size(), 0);

`ifdef HT_LANE_ARB_STATS_EN
    // 10 lookups, 3 of them hits
    rst = 1'b1; tick(); rst = 1'b0;
    chk("g_stat_rst", {stat_lookups, stat_hits}, '0);
    en = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      set_req(k % 4, (k < 3) ? 64'h0000_0001_0000_0100 + 64'(k) : 64'h0000_0000_0000_0200 + 64'(k));
      req_valid = 4'(1 << (k % 4));
      tick();
    end
    req_valid = '0; en = 1'b0;
    repeat (15) tick();
    chk("g_stat_lookups", stat_lookups, 32'd10);
    chk("g_stat_hits", stat_hits, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
